// File: rtl/sprite_pkg.sv
// Shared types for the sprite command FIFO: default field widths, the record
// layout, the record byte-count helper and the assembler state encoding.
package sprite_pkg;

  localparam int ID_W_DEFAULT    = 8;
  localparam int X_W_DEFAULT     = 16;
  localparam int Y_W_DEFAULT     = 16;
  localparam int SCALE_W_DEFAULT = 8;

  // Default-width record layout; id occupies the MSBs, matching wire order.
  typedef struct packed {
    logic [ID_W_DEFAULT-1:0]    id;
    logic [X_W_DEFAULT-1:0]     x;
    logic [Y_W_DEFAULT-1:0]     y;
    logic [SCALE_W_DEFAULT-1:0] scale;
  } sprite_rec_t;

  function automatic int record_bytes(input int id_w, input int x_w,
                                      input int y_w, input int scale_w);
    return (id_w + x_w + y_w + scale_w) / 8;
  endfunction

  typedef enum logic {IDLE, COLLECT} asm_state_e;

endpackage

// File: rtl/sprite_rec_assembler.sv
// Collects byte-serial sprite records (MSB byte first, fields id/x/y/scale)
// and emits a single-cycle rec_valid pulse together with the full record.
module sprite_rec_assembler
  import sprite_pkg::*;
#(
  parameter int ID_W    = ID_W_DEFAULT,
  parameter int X_W     = X_W_DEFAULT,
  parameter int Y_W     = Y_W_DEFAULT,
  parameter int SCALE_W = SCALE_W_DEFAULT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               strobe,
  input  logic                               enable,
  input  logic [7:0]                         byte_in,
  output logic                               rec_valid,
  output logic [ID_W+X_W+Y_W+SCALE_W-1:0]    rec
);

  localparam int NB    = record_bytes(ID_W, X_W, Y_W, SCALE_W);
  localparam int REC_W = NB * 8;
  localparam int IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  asm_state_e           state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [REC_W-9:0]     shreg_q;

  // The final byte is not registered: the record commits in its strobe cycle.
  assign rec_valid = (state_q == COLLECT) && strobe && enable &&
                     (idx_q == LAST_IDX) && !flush && !reset;
  assign rec       = {shreg_q, byte_in};

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe && enable) begin
            state_q <= COLLECT;
            idx_q   <= IDX_W'(1);
          end
        end
        COLLECT: begin
          if (!enable || rec_valid) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else if (strobe) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

  // Older bytes fall off the top, so at commit only this record's bytes remain.
  always_ff @(posedge clock) begin
    if (strobe && enable) shreg_q <= {shreg_q[REC_W-17:0], byte_in};
  end

endmodule

// File: rtl/sprite_fifo.sv
// Circular FIFO of sprite records fed by the byte-serial assembler.
// Optional macro SPRITE_FIFO_DROP_CNT_EN adds a saturating drop_count output.
module sprite_fifo
  import sprite_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ID_W    = ID_W_DEFAULT,
  parameter int X_W     = X_W_DEFAULT,
  parameter int Y_W     = Y_W_DEFAULT,
  parameter int SCALE_W = SCALE_W_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_clk,
  input  logic                       enqueue_en,
  input  logic [7:0]                 enqueue_data,
  input  logic                       flush,
  input  logic                       dequeue,
`ifdef SPRITE_FIFO_DROP_CNT_EN
  output logic [15:0]                drop_count,
`endif
  output logic                       valid,
  output logic                       is_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [ID_W-1:0]            sprite_id,
  output logic [X_W-1:0]             sprite_x,
  output logic [Y_W-1:0]             sprite_y,
  output logic [SCALE_W-1:0]         sprite_scale
);

  localparam int REC_W = ID_W + X_W + Y_W + SCALE_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [SCALE_W-1:0] scale;
  } rec_t;

  logic             data_clk_q;
  logic             strobe;
  logic             rec_valid;
  logic [REC_W-1:0] rec;
  logic [REC_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_write, do_pop, drop;
  rec_t             head;

  assign strobe = data_clk & ~data_clk_q;

  sprite_rec_assembler #(
    .ID_W    (ID_W),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .SCALE_W (SCALE_W)
  ) u_asm (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .strobe    (strobe),
    .enable    (enqueue_en),
    .byte_in   (enqueue_data),
    .rec_valid (rec_valid),
    .rec       (rec)
  );

  always_ff @(posedge clock) begin
    if (reset) data_clk_q <= 1'b1;
    else       data_clk_q <= data_clk;
  end

  // Fullness uses the pre-cycle count: a same-cycle pop never makes room.
  assign do_write = rec_valid && (count_q != FULL_CNT) && !flush;
  assign drop     = rec_valid && (count_q == FULL_CNT) && !flush;
  assign do_pop   = dequeue && (count_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_write) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_write && !reset) mem[wr_ptr_q] <= rec;
  end

`ifdef SPRITE_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush)                               drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
  assign overflow   = (drop_cnt_q != '0);
`else
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | drop;
    if (flush) overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

  // Head is a combinational read, masked to zero while empty.
  assign head         = rec_t'(mem[rd_ptr_q]);
  assign valid        = (count_q != '0);
  assign is_empty     = ~valid;
  assign count        = count_q;
  assign sprite_id    = valid ? head.id    : '0;
  assign sprite_x     = valid ? head.x     : '0;
  assign sprite_y     = valid ? head.y     : '0;
  assign sprite_scale = valid ? head.scale : '0;

endmodule

// File: doc/sprite_fifo.md
Name: sprite_fifo

Overview:
- Parametrised successor to the sprite command queue. Assembles byte-serial sprite records arriving from the SPI driver and buffers them in a circular FIFO.
- Presents the oldest record to the sprite renderer and pops it on request.
- Adds over the previous queue:
  - configurable depth and field widths;
  - pointer-based storage instead of a shift register;
  - explicit flush;
  - overflow reporting and an occupancy count.
- Sits between the SPI byte receiver and the sprite renderer, in the `clock` domain.

Parameters:
- DEPTH, 64, number of records; power of two, >= 2
- ID_W, 8, sprite id width; multiple of 8
- X_W, 16, x coordinate width; multiple of 8
- Y_W, 16, y coordinate width; multiple of 8
- SCALE_W, 8, scale width; multiple of 8

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_clk  in  1  SPI byte strobe; a byte is taken on each rising edge detected in `clock`
- enqueue_en  in  1  record stream enable; low discards any partial record
- enqueue_data  in  8  SPI byte
- flush  in  1  single-cycle pulse; empties FIFO and aborts assembly
- dequeue  in  1  level; pops head on each cycle where dequeue=1 and valid=1
- valid  out  1  head record present
- is_empty  out  1  equals ~valid
- count  out  $clog2(DEPTH+1)  records stored
- overflow  out  1  sticky; set when a completed record was dropped
- sprite_id  out  ID_W  head id
- sprite_x  out  X_W  head x
- sprite_y  out  Y_W  head y
- sprite_scale  out  SCALE_W  head scale

Behaviour:
- Single clock `clock`. Reset is synchronous and active-high.
- Reset values: valid=0, is_empty=1, count=0, overflow=0, all sprite_* outputs = 0. Pointers and byte index are 0. data_clk_q resets to 1, so a strobe already high at reset is not treated as an edge.
- Edge detect: strobe = data_clk & ~data_clk_q. data_clk_q is registered every cycle. enqueue_data is sampled in the strobe cycle.
- Record format: fields in the order id, x, y, scale. Each field is sent MSB byte first.
  - RECORD_BYTES = (ID_W+X_W+Y_W+SCALE_W)/8, which is 6 at the defaults.
- Assembler states:
  - IDLE: byte_idx=0.
    - strobe & enqueue_en → store byte 0, go to COLLECT.
  - COLLECT: each strobe & enqueue_en stores byte byte_idx into the assembly register and increments byte_idx.
    - On byte RECORD_BYTES-1: commit, return to IDLE.
    - strobe & ~enqueue_en → discard, go to IDLE.
    - enqueue_en low in any cycle → discard, go to IDLE.
- Commit behaviour:
  - If not full: write mem[wr_ptr], increment wr_ptr (wraps mod DEPTH), increment count.
  - If full (count==DEPTH): drop the record, set overflow, leave the FIFO unchanged.
  - A pop in the same cycle does not free space for the commit; the commit is evaluated against the pre-cycle count.
- Pop: when dequeue & valid, increment rd_ptr (wraps) and decrement count. Pop while empty is ignored with no side effects.
- Simultaneous commit and pop when 0<count<DEPTH: both happen and count is unchanged.
- Latency: a committed record is visible on the outputs in the cycle after the commit edge. After a pop, the next head appears the cycle after the pop edge.
- Head outputs: mem[rd_ptr], combinational read. Outputs are forced to 0 when count==0.
- Flush has highest priority:
  - sets pointers and count to 0 and the assembler to IDLE;
  - any same-cycle commit or pop is ignored;
  - overflow is cleared.
- Reset behaves like flush, and also clears data_clk_q to 1.
- Memory contents are never reset.

Optional Feature:
- Macro: SPRITE_FIFO_DROP_CNT_EN
- Defined:
  - Adds output port drop_count [15:0]. It increments on every dropped commit, saturates at 16'hFFFF, and is cleared by reset or flush.
  - overflow = (drop_count != 0).
- Undefined: no drop_count port, no counter logic; overflow is a plain sticky bit as specified above.

Decomposition:
- Package sprite_pkg holds:
  - field width defaults;
  - the sprite_rec_t packed struct {id, x, y, scale};
  - the RECORD_BYTES function;
  - the assembler state enum {IDLE, COLLECT}.
- One natural sub-module: sprite_rec_assembler. It takes the strobe, enable and byte inputs and emits a rec_valid pulse plus sprite_rec_t. The FIFO storage and pointers stay in sprite_fifo.

Test Plan:
- Reset, then bytes 01 00 C8 01 2C 02 with enqueue_en=1 → next cycle valid=1, count=1, id=1, x=200, y=300, scale=2.
- Drop enqueue_en after 3 bytes, then send a full record 05 00 0A 00 14 01 → count=1, id=5, x=10, y=20; the partial record never appears.
- Fill 64 records with id=0..63, then send a 65th with id=99 → count=64, overflow=1. Popping 64 times returns ids 0..63 in order, then valid=0. With SPRITE_FIFO_DROP_CNT_EN defined, drop_count=1.
- count=3 and last-byte commit coincides with a dequeue → count stays 3, head advances to the 2nd record, and the new record is read out 3rd.
- count=10 with assembly at byte 4, then flush pulse → next cycle count=0, valid=0, overflow=0. The next 6 bytes form a complete record.
- data_clk held high across reset release, then pulse dequeue while empty → no byte captured, count stays 0, no pointer movement.
